// File: rtl/regfile_pkg.sv
// regfile_pkg: shared FSM state type and default sizes for regfile_sb
package regfile_pkg;
  localparam int WIDTH_D = 32;
  localparam int DEPTH_D = 16;
  typedef enum logic {IDLE, CLEAR} state_t;
endpackage

// File: rtl/regfile_clr_fsm.sv
// regfile_clr_fsm: sequential bulk-clear engine, one register per cycle for DEPTH cycles
module regfile_clr_fsm import regfile_pkg::*; #(
  parameter int DEPTH = DEPTH_D,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic          busy,
  output logic          start,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);
  state_t state, nxt;
  logic [AW-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= state == CLEAR ? cnt + 1'b1 : '0;
    end
  end
  always_comb begin
    nxt = state;
    nxt = state == IDLE ? (clr ? CLEAR : IDLE) : (cnt == AW'(DEPTH - 1) ? IDLE : CLEAR);
  end
  assign busy = state == CLEAR;
  assign start = state == IDLE && clr;
  assign clr_we = busy;
  assign clr_addr = cnt;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 2R1W register file with pending scoreboard and bulk clear
// Optional write-to-read bypass: define REGFILE_SB_BYPASS_EN
module regfile_sb import regfile_pkg::*; #(
  parameter int WIDTH = WIDTH_D,
  parameter int DEPTH = DEPTH_D,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] y,
  input  logic             rsv,
  input  logic [AW-1:0]    ra_rsv,
  input  logic [AW-1:0]    i1,
  input  logic [AW-1:0]    i2,
  output logic [WIDTH-1:0] x1,
  output logic [WIDTH-1:0] x2,
  output logic             p1,
  output logic             p2,
  input  logic             clr,
  output logic             busy
);
  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pend;
  logic start, clr_we, wr, rs, q1, q2;
  logic [AW-1:0] clr_addr;
  logic [WIDTH-1:0] d1, d2;
  regfile_clr_fsm #(.DEPTH(DEPTH)) u_fsm (
    .clk(clk), .rst(rst), .clr(clr), .busy(busy),
    .start(start), .clr_we(clr_we), .clr_addr(clr_addr)
  );
  // the cycle that starts a clear also drops that cycle's write and reservation
  assign wr = we && !busy && !clr;
  assign rs = rsv && !busy && !clr;
`ifdef REGFILE_SB_BYPASS_EN
  logic pw;
  assign pw = rs && ra_rsv == wa;
  assign d1 = wr && i1 == wa ? y : regs[i1];
  assign d2 = wr && i2 == wa ? y : regs[i2];
  assign q1 = wr && i1 == wa ? pw : pend[i1];
  assign q2 = wr && i2 == wa ? pw : pend[i2];
`else
  assign d1 = regs[i1];
  assign d2 = regs[i2];
  assign q1 = pend[i1];
  assign q2 = pend[i2];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '{default: '0};
      pend <= '0;
      x1 <= '0;
      x2 <= '0;
      p1 <= 1'b0;
      p2 <= 1'b0;
    end else begin
      x1 <= d1;
      x2 <= d2;
      p1 <= q1;
      p2 <= q2;
      if (clr_we) regs[clr_addr] <= '0;
      if (wr) begin
        regs[wa] <= y;
        pend[wa] <= 1'b0;
      end
      if (rs) pend[ra_rsv] <= 1'b1;
      if (start) pend <= '0;
    end
  end
endmodule
